// File: rtl/rx_pkg.sv
// Shared receiver constants: default code geometry, sync header and FSM encoding.
// Imported by the deserializer, its sync detector and the receiver wrapper.
package rx_pkg;

  localparam int RX_HADAMARD      = 16;
  localparam int RX_PAM_LEVEL_LOG = 2;
  localparam int RX_BIT_NUM       = $clog2(RX_HADAMARD) + RX_PAM_LEVEL_LOG;
  localparam int SYNC_LEN         = 4;

  // Header pattern; an all-zero word would alias the cleared window.
  localparam logic [SYNC_LEN-1:0] RX_SYNC_WORD = 4'b1011;

  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  function automatic int payload_bits(input int bit_num, input int hadamard);
    return bit_num * hadamard;
  endfunction

  function automatic int frame_bits(input int bit_num, input int hadamard);
    return payload_bits(bit_num, hadamard) + SYNC_LEN;
  endfunction

  localparam int RX_PAYLOAD = payload_bits(RX_BIT_NUM, RX_HADAMARD);
  localparam int RX_N       = frame_bits(RX_BIT_NUM, RX_HADAMARD);

endpackage

// File: rtl/rx_frame_deserializer_sync_detector.sv
// Sliding-window sync header detector: flags the bit that completes the header,
// but only once enough real bits have arrived since the last clear.
module sync_detector
  import rx_pkg::*;
#(
  parameter logic [SYNC_LEN-1:0] SYNC_WORD = RX_SYNC_WORD
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic shift_en,
  input  logic bit_in,
  output logic match
);

  localparam logic [2:0] FILL_FULL = 3'd4;
  localparam logic [2:0] FILL_MIN  = 3'd3;

  // The 4-bit window is {history, bit_in}; the oldest bit would leave on this
  // shift anyway, so only the three newest bits are stored.
  logic [SYNC_LEN-2:0] history;
  logic [2:0]          fill;

  assign match = shift_en && (fill >= FILL_MIN) && ({history, bit_in} == SYNC_WORD);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      history <= '0;
      fill    <= '0;
    end else if (shift_en) begin
      history <= {history[SYNC_LEN-3:0], bit_in};
      if (fill != FILL_FULL) begin
        fill <= fill + 3'd1;
      end
    end
  end

endmodule

// File: rtl/rx_frame_deserializer.sv
// Serial-to-parallel frame front end: hunts for the sync header, collects the
// payload MSB-first and holds one finished frame behind a valid/ready handshake.
module rx_frame_deserializer
  import rx_pkg::*;
#(
  parameter int                  HADAMARD      = RX_HADAMARD,
  parameter int                  PAM_LEVEL_LOG = RX_PAM_LEVEL_LOG,
  parameter int                  BIT_NUM       = $clog2(HADAMARD) + PAM_LEVEL_LOG,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD     = RX_SYNC_WORD,
  localparam int                 PAYLOAD       = payload_bits(BIT_NUM, HADAMARD),
  localparam int                 N             = frame_bits(BIT_NUM, HADAMARD)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_in,
  input  logic         serial_valid,
  output logic [N-1:0] frame_data,
  output logic         frame_valid,
  input  logic         frame_ready,
  output logic         frame_overflow,
  output logic         hunting
);

  localparam int               CNT_W    = $clog2(PAYLOAD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD - 1);

  logic [0:0]         state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [PAYLOAD-1:0] payload;
  logic [PAYLOAD-1:0] payload_next;
  logic               hunt_shift;
  logic               collect_shift;
  logic               sync_match;
  logic               complete;

  assign hunt_shift    = serial_valid && (state == ST_HUNT);
  assign collect_shift = serial_valid && (state == ST_COLLECT);
  assign complete      = collect_shift && (bit_cnt == CNT_LAST);
  assign payload_next  = {payload[PAYLOAD-2:0], serial_in};

  sync_detector #(
    .SYNC_WORD (SYNC_WORD)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .clear    (complete),
    .shift_en (hunt_shift),
    .bit_in   (serial_in),
    .match    (sync_match)
  );

  // hunting is kept as its own flop so the status output is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_HUNT;
      hunting <= 1'b1;
      bit_cnt <= '0;
      payload <= '0;
    end else if (hunt_shift && sync_match) begin
      state   <= ST_COLLECT;
      hunting <= 1'b0;
      bit_cnt <= '0;
    end else if (collect_shift) begin
      payload <= payload_next;
      if (complete) begin
        state   <= ST_HUNT;
        hunting <= 1'b1;
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  // A completing frame may replace the buffered one only if it is leaving
  // on this same edge; otherwise the new frame is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_data     <= '0;
      frame_valid    <= 1'b0;
      frame_overflow <= 1'b0;
    end else begin
      frame_overflow <= 1'b0;
      if (complete) begin
        if (!frame_valid || frame_ready) begin
          frame_data  <= {SYNC_WORD, payload_next};
          frame_valid <= 1'b1;
        end else begin
          frame_overflow <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rx_frame_deserializer.md
Name: rx_frame_deserializer

Overview:
- Receiver front-end stage that sits directly upstream of the Hadamard/PAM receiver wrapper.
- Hunts a serial bitstream for a 4-bit sync header, then collects BIT_NUM*HADAMARD payload bits.
- Presents the full N-bit frame (header plus payload) in parallel with a valid/ready handshake.
- Single-frame output buffer, so the next frame can be collected while the receiver still holds the current one.

Parameters:
- HADAMARD, 16, Hadamard code length (symbols per frame).
- PAM_LEVEL_LOG, 2, log2 of PAM levels.
- BIT_NUM, 6, bits per symbol = log2(HADAMARD)+PAM_LEVEL_LOG.
- SYNC_WORD, 4'b1011, frame header pattern; must not be 4'b0000.
- N (localparam), BIT_NUM*HADAMARD+4 = 100, frame width.
- PAYLOAD (localparam), BIT_NUM*HADAMARD = 96.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- serial_in  in  1  received bit, sampled only when serial_valid=1.
- serial_valid  in  1  bit strobe, one bit per asserted cycle.
- frame_data  out  N  assembled frame; [N-1:N-4]=sync word, then payload MSB-first (first received payload bit at index N-5).
- frame_valid  out  1  frame_data holds an unconsumed frame.
- frame_ready  in  1  downstream accepts frame when frame_valid&frame_ready at clk edge.
- frame_overflow  out  1  one-cycle pulse: a completed frame was dropped.
- hunting  out  1  1 while in HUNT state (status/debug).

Behaviour:
Reset, synchronous and dominant over all other inputs:
- frame_data=0, frame_valid=0, frame_overflow=0, hunting=1.
- State=HUNT, sync window=0, window fill count=0, payload counter=0.

State HUNT:
- On each serial_valid, shift serial_in into the LSB of the 4-bit window; fill count saturates at 4.
- Match requires fill count ≥3 before the shift, with {window[2:0],serial_in}==SYNC_WORD. This prevents a false match on reset zeros.
- On a match, go to COLLECT next cycle with counter=0.
- Overlapping matches are allowed (e.g. 1011011 syncs at bit 4).

State COLLECT:
- On each serial_valid, shift serial_in into the payload shift register and increment the counter.
- The counter is $clog2(PAYLOAD) bits wide and counts 0..PAYLOAD-1.
- On the bit where counter==PAYLOAD-1, the frame is complete:
  - load {SYNC_WORD, payload} into the output buffer;
  - clear the window and fill count;
  - return to HUNT.
- Cycles with serial_valid=0 hold all state; there is no timeout.

Output buffer / handshake:
- Completion at edge k gives frame_data/frame_valid updated after edge k (latency 0 cycles after the last bit is sampled, visible in cycle k+1).
- frame_valid stays high and frame_data stays stable until accepted.
- Accept (valid&ready) with no new completion: frame_valid=0 next cycle; frame_data keeps its last value.
- Completion while frame_valid=0: load the frame, frame_valid=1.
- Completion together with accept in the same cycle: load the new frame, frame_valid stays 1, no overflow.
- Completion while frame_valid=1 and frame_ready=0: drop the new frame, keep the old one, pulse frame_overflow for exactly one cycle.
- frame_ready while frame_valid=0 is ignored.
- hunting is a registered output that equals (state==HUNT).

Reset mid-frame:
- Any partial frame and any buffered frame are discarded.
- No frame_valid appears until a complete new header plus payload is received.

Decomposition:
- Shared package (rx_pkg) holds:
  - HADAMARD, PAM_LEVEL_LOG and BIT_NUM defaults;
  - SYNC_WORD and the N/PAYLOAD formulas;
  - the state encoding (HUNT=1'b0, COLLECT=1'b1).
  These are reused by the receiver wrapper and the bench.
- One sub-module is natural: sync_detector, holding the 4-bit window, fill counter and match output. The FSM, payload shifter and output buffer stay in the top module.

Test Plan:
- Basic frame: reset, send 1011 then 96 payload bits equal to 96'hA5A5_..._A5 with serial_valid=1 continuously, ready=1. Expect frame_valid high for 1 cycle with frame_data={4'b1011,96'hA5..A5}, one cycle after the last bit edge; hunting returns to 1.
- Noise and overlap: send 0001 1011 0110 11 then payload. Expect sync on the first 1011 (bit 8). A second run of 101 1011 syncs on the overlapping pattern. Verify no sync within 3 bits after reset even with serial_in=1.
- Gapped strobe: same frame as the basic test with serial_valid toggling 1/0 every cycle. Expect an identical frame_data; completion is delayed to about 2×100 cycles.
- Backpressure/overflow: ready=0, send frames F1 then F2. Expect frame_data=F1 held and frame_overflow pulsed once at F2 completion. Raise ready: F1 is accepted, and frame_valid drops.
- Simultaneous accept+complete: hold F1 with ready=0, then assert ready exactly on F2's last-bit edge. Expect frame_valid to stay 1, frame_data=F2, frame_overflow=0.
- Reset mid-frame: assert reset after 50 payload bits, then send 46 more bits. Expect no frame_valid. A following clean frame is received correctly.
